// File: rtl/hazard_control_unit_if.sv
// Bundle between the pipeline datapath and the hazard control unit:
// register/load status in, stage enables, flushes and performance counters out.
interface hazard_control_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IF_ID_rs1;
    logic [4:0]       IF_ID_rs2;
    logic             uses_rs2;
    logic             branch;
    logic             branch_taken;
    logic [4:0]       ID_EX_rd;
    logic [4:0]       EX_MEM_rd;
    logic             ID_EX_mem_read;
    logic             EX_MEM_mem_read;
    logic             mem_busy;
    logic             pc_write;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic             ID_EX_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output IF_ID_rs1, IF_ID_rs2, uses_rs2, branch, branch_taken,
               ID_EX_rd, EX_MEM_rd, ID_EX_mem_read, EX_MEM_mem_read, mem_busy,
        input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, stall_cnt, flush_cnt
    );

    modport slave (
        input  IF_ID_rs1, IF_ID_rs2, uses_rs2, branch, branch_taken,
               ID_EX_rd, EX_MEM_rd, ID_EX_mem_read, EX_MEM_mem_read, mem_busy,
        output pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Load-use / branch-compare hazard detection for a 5-stage pipeline with
// ID-stage branch resolution, plus saturating stall and flush counters.
module hazard_control_unit #(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_control_unit_if.slave  hif
);
    typedef enum logic [1:0] {RUN = 2'd0, STALL2 = 2'd1, STALL1 = 2'd2} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             ex_hit, mem_hit;
    logic             load_use, br_ex, br_mem;
    logic             stall, stall_inc, flush_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // x0 is hardwired zero, so a write to it never creates a dependency
    assign ex_hit  = (hif.ID_EX_rd != 5'd0) &&
                     ((hif.ID_EX_rd == hif.IF_ID_rs1) ||
                      (hif.uses_rs2 && (hif.ID_EX_rd == hif.IF_ID_rs2)));
    assign mem_hit = (hif.EX_MEM_rd != 5'd0) &&
                     ((hif.EX_MEM_rd == hif.IF_ID_rs1) ||
                      (hif.uses_rs2 && (hif.EX_MEM_rd == hif.IF_ID_rs2)));

    // ALU results are forwarded into the compare stage; only loads stall
    assign load_use = !hif.branch && hif.ID_EX_mem_read && ex_hit;
    assign br_ex    = hif.branch && hif.ID_EX_mem_read && ex_hit;
    assign br_mem   = hif.branch && hif.EX_MEM_mem_read && mem_hit && !br_ex;

    always_comb begin
        state_d          = state_q;
        stall            = 1'b0;
        hif.pc_write     = 1'b1;
        hif.IF_ID_write  = 1'b1;
        hif.ID_EX_flush  = 1'b0;
        hif.IF_ID_flush  = 1'b0;

        unique case (state_q)
            RUN: begin
                if (br_ex) begin
                    stall   = 1'b1;
                    state_d = STALL1;
                end else if (load_use || br_mem) begin
                    stall   = 1'b1;
                end
            end
            STALL2: begin
                stall   = 1'b1;
                state_d = STALL1;
            end
            STALL1: begin
                stall   = 1'b1;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        if (stall) begin
            hif.pc_write    = 1'b0;
            hif.IF_ID_write = 1'b0;
            hif.ID_EX_flush = 1'b1;
        end else begin
            hif.IF_ID_flush = hif.branch_taken;
        end

        // A busy memory freezes every stage without inserting a bubble
        if (hif.mem_busy) begin
            state_d         = state_q;
            hif.pc_write    = 1'b0;
            hif.IF_ID_write = 1'b0;
            hif.ID_EX_flush = 1'b0;
            hif.IF_ID_flush = 1'b0;
        end

        if (!rst_n) begin
            hif.pc_write    = 1'b0;
            hif.IF_ID_write = 1'b0;
            hif.ID_EX_flush = 1'b1;
            hif.IF_ID_flush = 1'b0;
        end
    end

    assign stall_inc = stall && !hif.mem_busy;
    assign flush_inc = !stall && !hif.mem_busy && hif.branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall_inc) stall_cnt_q <= sat_inc(stall_cnt_q);
            if (flush_inc) flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign hif.stall_cnt = stall_cnt_q;
    assign hif.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: a 16-bit-counter instance and a
// 4-bit-counter instance share stimulus; vectors are table-driven plus sequences.
module tb_hazard_control_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [4:0] rs1, rs2, ex_rd, mem_rd;
    logic       uses_rs2, branch, taken, ex_mr, mem_mr, busy;

    hazard_control_unit_if #(.CNT_W(16)) hif16 ();
    hazard_control_unit_if #(.CNT_W(4))  hif4 ();

    assign hif16.IF_ID_rs1 = rs1;       assign hif4.IF_ID_rs1 = rs1;
    assign hif16.IF_ID_rs2 = rs2;       assign hif4.IF_ID_rs2 = rs2;
    assign hif16.uses_rs2 = uses_rs2;   assign hif4.uses_rs2 = uses_rs2;
    assign hif16.branch = branch;       assign hif4.branch = branch;
    assign hif16.branch_taken = taken;  assign hif4.branch_taken = taken;
    assign hif16.ID_EX_rd = ex_rd;      assign hif4.ID_EX_rd = ex_rd;
    assign hif16.EX_MEM_rd = mem_rd;    assign hif4.EX_MEM_rd = mem_rd;
    assign hif16.ID_EX_mem_read = ex_mr;   assign hif4.ID_EX_mem_read = ex_mr;
    assign hif16.EX_MEM_mem_read = mem_mr; assign hif4.EX_MEM_mem_read = mem_mr;
    assign hif16.mem_busy = busy;       assign hif4.mem_busy = busy;

    hazard_control_unit #(.CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .hif(hif16));
    hazard_control_unit #(.CNT_W(4))  dut4  (.clk(clk), .rst_n(rst_n), .hif(hif4));

    typedef struct {
        logic [4:0] rs1, rs2, ex_rd, mem_rd;
        logic       uses_rs2, branch, taken, ex_mr, mem_mr, busy;
        logic [3:0] exp;  // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush}
    } vec_t;

    localparam logic [3:0] O_RUN   = 4'b1100;
    localparam logic [3:0] O_FLUSH = 4'b1110;
    localparam logic [3:0] O_STALL = 4'b0001;
    localparam logic [3:0] O_FROZE = 4'b0000;

    int n_cmp = 0;
    int n_err = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    vec_t vecs[12];

    function automatic int sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [3:0] exp);
        chk(name, {28'd0, hif16.pc_write, hif16.IF_ID_write, hif16.IF_ID_flush, hif16.ID_EX_flush},
            {28'd0, exp});
    endtask

    task automatic chk_cnt(input string name);
        chk({name, " stall_cnt16"}, {16'd0, hif16.stall_cnt}, exp_stall);
        chk({name, " flush_cnt16"}, {16'd0, hif16.flush_cnt}, exp_flush);
        chk({name, " stall_cnt4"}, {28'd0, hif4.stall_cnt}, sat4(exp_stall));
        chk({name, " flush_cnt4"}, {28'd0, hif4.flush_cnt}, sat4(exp_flush));
    endtask

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0;
        uses_rs2 = 1'b0; branch = 1'b0; taken = 1'b0;
        ex_mr = 1'b0; mem_mr = 1'b0; busy = 1'b0;
    endtask

    // Drive inputs after a falling edge, check outputs, let the rising edge commit
    task automatic cycle(input string name, input logic [3:0] exp);
        #1;
        chk_out(name, exp);
        if (!busy && exp == O_STALL) exp_stall++;
        if (!busy && exp[1]) exp_flush++;
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    task automatic branch_load_ex();
        idle();
        branch = 1'b1; ex_mr = 1'b1; ex_rd = 5'd3; rs2 = 5'd3; uses_rs2 = 1'b1; taken = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //                rs1   rs2   ex_rd mem_rd u2  br  tk  exmr memr busy exp
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, O_RUN};
        vecs[1]  = '{5'd5, 5'd0, 5'd5, 5'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, O_STALL};
        vecs[2]  = '{5'd0, 5'd7, 5'd7, 5'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, O_RUN};
        vecs[3]  = '{5'd0, 5'd7, 5'd7, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, O_STALL};
        vecs[4]  = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, O_RUN};
        vecs[5]  = '{5'd5, 5'd0, 5'd5, 5'd0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, O_FLUSH};
        vecs[6]  = '{5'd4, 5'd0, 5'd0, 5'd4, 1'b0,1'b1,1'b1,1'b0,1'b1,1'b0, O_STALL};
        vecs[7]  = '{5'd4, 5'd0, 5'd0, 5'd4, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, O_RUN};
        vecs[8]  = '{5'd5, 5'd0, 5'd5, 5'd0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b1, O_FROZE};
        vecs[9]  = '{5'd1, 5'd2, 5'd9, 5'd8, 1'b1,1'b1,1'b1,1'b1,1'b1,1'b0, O_FLUSH};
        vecs[10] = '{5'd6, 5'd0, 5'd6, 5'd0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, O_STALL};
        vecs[11] = '{5'd0, 5'd9, 5'd0, 5'd9, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, O_RUN};

        // Reset: outputs forced regardless of a load-use hazard and a taken branch
        idle();
        rs1 = 5'd5; ex_rd = 5'd5; ex_mr = 1'b1; taken = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk_out("reset outputs", O_STALL);
        chk_cnt("reset");
        idle();
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; ex_rd = vecs[i].ex_rd; mem_rd = vecs[i].mem_rd;
            uses_rs2 = vecs[i].uses_rs2; branch = vecs[i].branch; taken = vecs[i].taken;
            ex_mr = vecs[i].ex_mr; mem_mr = vecs[i].mem_mr; busy = vecs[i].busy;
            cycle($sformatf("vec%0d outputs", i), vecs[i].exp);
            chk_cnt($sformatf("vec%0d", i));
        end

        // Branch after a load in EX: two stall cycles, then the taken branch flushes
        branch_load_ex();
        cycle("brld stall1", O_STALL);
        cycle("brld stall2", O_STALL);
        ex_mr = 1'b0;
        cycle("brld resolve", O_FLUSH);
        chk_cnt("brld");

        // mem_busy for three cycles while in STALL1
        branch_load_ex();
        cycle("busy enter", O_STALL);
        busy = 1'b1;
        for (int i = 0; i < 3; i++) cycle($sformatf("busy%0d", i), O_FROZE);
        chk_cnt("busy held");
        busy = 1'b0; ex_mr = 1'b0;
        cycle("busy release stall", O_STALL);
        taken = 1'b0;
        cycle("busy back to run", O_RUN);
        chk_cnt("busy");

        // Twenty load-use stalls saturate the 4-bit counter
        idle();
        rs1 = 5'd5; ex_rd = 5'd5; ex_mr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (hif16.ID_EX_flush !== 1'b1 || hif16.pc_write !== 1'b0) begin
                chk_out($sformatf("sat stall%0d", i), O_STALL);
            end
            exp_stall++;
            @(negedge clk);
        end
        chk_cnt("saturate");
        chk("sat4 all ones", {28'd0, hif4.stall_cnt}, 32'd15);

        // Reset pulsed while in STALL1 takes effect without a clock edge
        branch_load_ex();
        cycle("rst enter", O_STALL);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rst mid-stall outputs", O_STALL);
        exp_stall = 0; exp_flush = 0;
        chk_cnt("rst mid-stall");
        chk("rst dut4 flush", {31'd0, hif4.ID_EX_flush}, 32'd1);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        cycle("after rst run", O_RUN);
        chk_cnt("after rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter CNT_W, default 16, width of the saturating performance counters.
REQ-002 clk  in  1  core clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 IF_ID_rs1, IF_ID_rs2  in  5 each  source registers of the instruction in ID.
REQ-005 uses_rs2  in  1  instruction in ID reads rs2.
REQ-006 branch  in  1  instruction in ID is a conditional branch, compared in ID.
REQ-007 branch_taken  in  1  branch in ID resolved taken this cycle.
REQ-008 ID_EX_rd, EX_MEM_rd  in  5 each  destination registers in EX and MEM.
REQ-009 ID_EX_mem_read, EX_MEM_mem_read  in  1 each  load in EX, load in MEM.
REQ-010 mem_busy  in  1  data memory not ready; freezes the whole pipeline.
REQ-011 pc_write  out  1  PC update enable.
REQ-012 IF_ID_write  out  1  IF/ID register enable.
REQ-013 IF_ID_flush  out  1  squash the instruction in IF/ID.
REQ-014 ID_EX_flush  out  1  insert a bubble into ID/EX.
REQ-015 stall_cnt, flush_cnt  out  CNT_W each  saturating counts of stall cycles and flushes.

Function
REQ-016 FSM states: RUN, STALL2, STALL1.
REQ-017 ex_hit: ID_EX_rd != 0 and (ID_EX_rd == IF_ID_rs1, or uses_rs2 and ID_EX_rd == IF_ID_rs2).
REQ-018 mem_hit: the same test as ex_hit, using EX_MEM_rd.
REQ-019 In RUN, a hazard is detected combinationally in the same cycle, with no added latency.
REQ-020 Load-use (RUN, !branch, ID_EX_mem_read, ex_hit): stall this cycle; next state RUN.
REQ-021 Branch after load in EX (RUN, branch, ID_EX_mem_read, ex_hit): stall this cycle; next state STALL1.
REQ-022 Branch after load in MEM (RUN, branch, EX_MEM_mem_read, mem_hit, no REQ-021 hit): stall this cycle; next state RUN.
REQ-023 ALU results from EX or MEM are forwarded to the compare stage, so they cause no stall.
REQ-024 STALL2 is reserved for a two-cycle committed stall; it always goes to STALL1.
REQ-025 STALL1 stalls unconditionally and then goes to RUN; detection is re-evaluated in RUN.
REQ-026 Stall cycle outputs: pc_write=0, IF_ID_write=0, ID_EX_flush=1, IF_ID_flush=0.
REQ-027 Normal cycle outputs: pc_write=1, IF_ID_write=1, ID_EX_flush=0, IF_ID_flush=branch_taken.
REQ-028 branch_taken is ignored during any stall cycle.
REQ-029 mem_busy=1 overrides all else: pc_write=0, IF_ID_write=0, ID_EX_flush=0, IF_ID_flush=0.
REQ-030 mem_busy=1 holds the FSM state and both counters.
REQ-031 stall_cnt increments by 1 per stall cycle (REQ-026); it saturates at all-ones.
REQ-032 flush_cnt increments by 1 per cycle with IF_ID_flush=1; it saturates at all-ones.
REQ-033 Simultaneous stall condition and branch_taken: the stall wins and no flush is counted.

Reset
REQ-034 While rst_n=0: state=RUN, stall_cnt=0, flush_cnt=0.
REQ-035 While rst_n=0: pc_write=0, IF_ID_write=0, ID_EX_flush=1, IF_ID_flush=0, regardless of the other inputs.
REQ-036 Reset asserted mid-stall aborts the stall at once and applies REQ-034 and REQ-035 asynchronously.
REQ-037 The first edge after rst_n rises evaluates from RUN.

Verification
REQ-038 Load-use: ID_EX_mem_read=1, ID_EX_rd=5, IF_ID_rs1=5, branch=0 -> one cycle with pc_write=0 and ID_EX_flush=1, then pc_write=1; stall_cnt=1.
REQ-039 rs2 gating: ID_EX_rd=7, IF_ID_rs2=7, uses_rs2=0 -> no stall; same inputs with uses_rs2=1 -> one stall cycle.
REQ-040 Branch after load: branch=1, ID_EX_mem_read=1, ID_EX_rd=3, IF_ID_rs2=3, uses_rs2=1 -> two consecutive stall cycles, then branch_taken=1 gives IF_ID_flush=1; stall_cnt=2, flush_cnt=1.
REQ-041 x0: ID_EX_mem_read=1, ID_EX_rd=0, IF_ID_rs1=0 -> no stall.
REQ-042 mem_busy=1 for 3 cycles in STALL1 -> all enables 0, state and counters held, then one stall cycle, then RUN.
REQ-043 Saturation and reset: CNT_W=4 with 20 stall cycles -> stall_cnt=15; rst_n pulsed low in STALL1 -> counters 0 and ID_EX_flush=1 immediately.
